// File: rtl/display_scanner.sv
// Multiplexed common-anode 7-segment scanner for a parking counter. It alternates
// an "L" (free) page and an "o" (busy) page, and snapshots both counts at each page start.
module display_scanner #(
  parameter int N_DIG        = 4,
  parameter int CNT_W        = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int PAGE_FRAMES  = 500,
  parameter int BLINK_FRAMES = 125
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] free,
  input  logic [CNT_W-1:0] busy,
  output logic [6:0]       seg,
  output logic             dp,
  output logic [N_DIG-1:0] dig
);
  localparam int PW   = $clog2(SCAN_DIV);
  localparam int IW   = $clog2(N_DIG);
  localparam int FW   = (PAGE_FRAMES  > 1) ? $clog2(PAGE_FRAMES)  : 1;
  localparam int BW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int MAXV = 10**(N_DIG-1) - 1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_O     = 7'b0100011;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  logic [PW-1:0]    presc_q, presc_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [FW-1:0]    frm_q, frm_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic             page_q, page_d, blink_q, blink_d, started_q;
  logic [CNT_W-1:0] snap_free_q, snap_free_d, snap_busy_q, snap_busy_d, cur_d;
  logic [6:0]       seg_q, seg_d;
  logic [N_DIG-1:0] dig_q, dig_d;
  logic             tick, frame_end, page_wrap, blink_wrap, snap_ld;
  logic [31:0]      v, pw;

  always_comb begin
    tick       = (presc_q == PW'(SCAN_DIV-1));
    frame_end  = tick && (idx_q == IW'(N_DIG-1));
    page_wrap  = frame_end && (frm_q == FW'(PAGE_FRAMES-1));
    blink_wrap = frame_end && (bcnt_q == BW'(BLINK_FRAMES-1));

    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (tick) idx_d = (idx_q == IW'(N_DIG-1)) ? '0 : idx_q + 1'b1;
    frm_d   = frm_q;
    if (frame_end) frm_d = page_wrap ? '0 : frm_q + 1'b1;
    bcnt_d  = bcnt_q;
    if (frame_end) bcnt_d = blink_wrap ? '0 : bcnt_q + 1'b1;
    page_d  = page_q ^ page_wrap;
    blink_d = blink_q ^ blink_wrap;

    // The first edge out of reset counts as a page start, so a fresh snapshot is taken then.
    snap_ld     = !started_q || page_wrap;
    snap_free_d = snap_ld ? free : snap_free_q;
    snap_busy_d = snap_ld ? busy : snap_busy_q;
    cur_d       = page_d ? snap_busy_d : snap_free_d;

    // Output registers are loaded from next-state values, giving one cycle of latency after the tick.
    seg_d = SEG_BLANK;
    v     = 32'(cur_d);
    pw    = 32'd1;
    for (int k = 0; k < N_DIG-1; k++) begin
      if (idx_d == IW'(N_DIG-1-k)) begin
        if (v > 32'(MAXV))          seg_d = SEG_DASH;
        else if (k == 0 || v >= pw) seg_d = seg7(4'((v / pw) % 32'd10));
      end
      pw = pw * 32'd10;
    end
    if (idx_d == '0) seg_d = page_d ? SEG_O : SEG_L;

    // Anodes are dark for the first cycle of every slot, and dark for whole frames while blinking a zero.
    if ((presc_d == '0) || ((snap_free_d == '0) && blink_d))
      dig_d = '1;
    else
      dig_d = ~({{(N_DIG-1){1'b0}}, 1'b1} << idx_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q     <= '0;
      idx_q       <= '0;
      frm_q       <= '0;
      bcnt_q      <= '0;
      page_q      <= 1'b0;
      blink_q     <= 1'b0;
      started_q   <= 1'b0;
      snap_free_q <= '0;
      snap_busy_q <= '0;
      seg_q       <= SEG_BLANK;
      dig_q       <= '1;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      frm_q       <= frm_d;
      bcnt_q      <= bcnt_d;
      page_q      <= page_d;
      blink_q     <= blink_d;
      started_q   <= 1'b1;
      snap_free_q <= snap_free_d;
      snap_busy_q <= snap_busy_d;
      seg_q       <= seg_d;
      dig_q       <= dig_d;
    end
  end

  assign seg = seg_q;
  assign dig = dig_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_display_scanner.sv
// Scoreboard bench for display_scanner: three instances (4 digits, 2 digits, 4 digits with
// 10-bit counts) are checked each cycle against a string-formatting reference model.
module tb_display_scanner;
  localparam int SD = 4, PF = 2, BF = 1;
  localparam logic [6:0] GLYPH [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  typedef struct packed {
    int              e;
    logic [2:0][7:0] dig;
    logic [2:0][6:0] seg;
  } exp_t;

  logic       clk = 1'b0, clk_en = 1'b0, rst_n = 1'b1;
  logic [3:0] free, busy;
  logic [9:0] free_w, busy_w;
  logic [6:0] seg4, seg2, segw;
  logic       dp4, dp2, dpw;
  logic [3:0] dig4, digw;
  logic [1:0] dig2;

  display_scanner #(.N_DIG(4), .CNT_W(4), .SCAN_DIV(SD), .PAGE_FRAMES(PF), .BLINK_FRAMES(BF)) u4 (
    .clk(clk), .rst_n(rst_n), .free(free), .busy(busy), .seg(seg4), .dp(dp4), .dig(dig4));
  display_scanner #(.N_DIG(2), .CNT_W(4), .SCAN_DIV(SD), .PAGE_FRAMES(PF), .BLINK_FRAMES(BF)) u2 (
    .clk(clk), .rst_n(rst_n), .free(free), .busy(busy), .seg(seg2), .dp(dp2), .dig(dig2));
  display_scanner #(.N_DIG(4), .CNT_W(10), .SCAN_DIV(SD), .PAGE_FRAMES(PF), .BLINK_FRAMES(BF)) uw (
    .clk(clk), .rst_n(rst_n), .free(free_w), .busy(busy_w), .seg(segw), .dp(dpw), .dig(digw));

  initial forever begin #5; if (clk_en) clk = ~clk; end

  exp_t q[$];
  int   n_vec = 0, n_err = 0;
  int   e = 0;
  int   nd [3] = '{4, 2, 4};
  int   sf [3], sb [3];

  function automatic logic [7:0] ones(input int n);
    return 8'((1 << n) - 1);
  endfunction

  // Reference: position in the scan follows from the number of edges since release.
  function automatic void ref_out(input int n, input int ee, input int f, input int b,
                                  output logic [7:0] dg, output logic [6:0] sg);
    int fr, idx, page, blink, val, lim, off;
    string s;
    fr    = ee / (SD*n);
    idx   = (ee / SD) % n;
    page  = (fr / PF) % 2;
    blink = (fr / BF) % 2;
    val   = (page == 1) ? b : f;
    if ((ee % SD == 0) || (f == 0 && blink == 1)) dg = ones(n);
    else dg = ones(n) & ~(8'(1) << idx);
    if (idx == 0) sg = (page == 1) ? 7'b0100011 : 7'b1000111;
    else begin
      lim = 1;
      for (int i = 1; i < n; i++) lim *= 10;
      if (val >= lim) sg = 7'b0111111;
      else begin
        s   = $sformatf("%0d", val);
        off = (n-1) - s.len();
        if (idx-1 < off) sg = 7'b1111111;
        else sg = GLYPH[int'(s[idx-1-off]) - 48];
      end
    end
  endfunction

  task automatic cmp(input string nm, input int ee, input logic [7:0] ad, input logic [6:0] as,
                     input logic adp, input logic [7:0] ed, input logic [6:0] es);
    n_vec++;
    if (ad !== ed || as !== es || adp !== 1'b1) begin
      n_err++;
      $display("FAIL %s e=%0d dig=%b exp %b seg=%b exp %b dp=%b exp 1", nm, ee, ad, ed, as, es, adp);
    end
  endtask

  task automatic cmp_all(input string tag, input exp_t x);
    cmp({tag, "_n4"}, x.e, {4'b0, dig4}, seg4, dp4, x.dig[0], x.seg[0]);
    cmp({tag, "_n2"}, x.e, {6'b0, dig2}, seg2, dp2, x.dig[1], x.seg[1]);
    cmp({tag, "_w10"}, x.e, {4'b0, digw}, segw, dpw, x.dig[2], x.seg[2]);
  endtask

  function automatic exp_t blank_exp();
    exp_t x;
    x.e = -1;
    for (int k = 0; k < 3; k++) begin x.dig[k] = ones(nd[k]); x.seg[k] = 7'b1111111; end
    return x;
  endfunction

  // Called at a negedge: predicts the outputs after the coming posedge.
  task automatic step();
    exp_t x;
    logic [7:0] dg;
    logic [6:0] sg;
    e++;
    for (int k = 0; k < 3; k++) begin
      if (e == 1 || e % (PF*nd[k]*SD) == 0) begin
        sf[k] = (k == 2) ? int'(free_w) : int'(free);
        sb[k] = (k == 2) ? int'(busy_w) : int'(busy);
      end
      ref_out(nd[k], e, sf[k], sb[k], dg, sg);
      x.dig[k] = dg;
      x.seg[k] = sg;
    end
    x.e = e;
    q.push_back(x);
  endtask

  initial forever begin
    exp_t x;
    @(posedge clk); #1;
    if (q.size() > 0) begin
      x = q.pop_front();
      cmp_all("scan", x);
    end
  end

  function automatic logic [9:0] pick_w();
    case ($urandom_range(0, 3))
      0:       return 10'd0;
      1:       return 10'd999;
      2:       return 10'd1000;
      default: return 10'($urandom_range(0, 1023));
    endcase
  endfunction

  initial begin
    free = 4'd3; busy = 4'd1; free_w = 10'd0; busy_w = 10'd999;
    #1 rst_n = 1'b0;
    #2 cmp_all("async_rst", blank_exp());
    clk_en = 1'b1;
    repeat (2) begin @(negedge clk); q.push_back(blank_exp()); end
    @(negedge clk);
    rst_n = 1'b1; e = 0;
    // Mid-page change of free must stay hidden until the next free page.
    for (int c = 0; c < 96; c++) begin
      if (c == 10) free = 4'd7;
      step();
      @(negedge clk);
    end
    // Blinking zero, multi-digit busy, overflow dashes on the narrow display.
    free = 4'd0; busy = 4'd15; free_w = 10'd0; busy_w = 10'd1000;
    for (int c = 0; c < 128; c++) begin step(); @(negedge clk); end
    busy = 4'd9; free_w = 10'd120; busy_w = 10'd7;
    for (int c = 0; c < 64; c++) begin step(); @(negedge clk); end
    // Reset pulse in the middle of a page.
    free = 4'd5; busy = 4'd12;
    for (int c = 0; c < 45; c++) begin step(); @(negedge clk); end
    rst_n = 1'b0;
    #1 cmp_all("mid_rst", blank_exp());
    q.push_back(blank_exp());
    @(negedge clk);
    q.push_back(blank_exp());
    @(negedge clk);
    free = 4'd9; busy = 4'd2; free_w = 10'd45; busy_w = 10'd506;
    rst_n = 1'b1; e = 0;
    for (int c = 0; c < 80; c++) begin step(); @(negedge clk); end
    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 5) == 0) free   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) busy   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) free_w = pick_w();
      if ($urandom_range(0, 5) == 0) busy_w = pick_w();
      step();
      @(negedge clk);
    end
    @(negedge clk);
    if (q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL queue_drain left=%0d exp 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 The module SHALL have parameter N_DIG, default 4: number of common-anode digits, range 2..8.
REQ-002 The module SHALL have parameter CNT_W, default 4: width of the count inputs, range 1..10.
REQ-003 The module SHALL have parameter SCAN_DIV, default 50000: clk cycles per digit slot, minimum 4.
REQ-004 The module SHALL have parameter PAGE_FRAMES, default 500: full scan frames per page, minimum 1.
REQ-005 The module SHALL have parameter BLINK_FRAMES, default 125: frames per blink half-period, minimum 1.
REQ-006 The module SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-007 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 The module SHALL have port free, input, CNT_W bits: number of free parking spaces, unsigned.
REQ-009 The module SHALL have port busy, input, CNT_W bits: number of occupied parking spaces, unsigned.
REQ-010 The module SHALL have port seg, output, 7 bits: {g,f,e,d,c,b,a}, active-low, registered.
REQ-011 The module SHALL have port dp, output, 1 bit: decimal point, active-low, constant 1 (off).
REQ-012 The module SHALL have port dig, output, N_DIG bits: digit enables, active-low, registered; bit 0 is the leftmost digit (D1).

Function
REQ-013 The prescaler SHALL count 0..SCAN_DIV-1 and wrap; a tick SHALL occur in the cycle where it equals SCAN_DIV-1.
REQ-014 On each tick, the digit index SHALL advance 0..N_DIG-1 and wrap; a frame SHALL end on the tick where the index wraps to 0.
REQ-015 The frame counter SHALL count frame ends 0..PAGE_FRAMES-1; at the wrap it SHALL toggle the page (0 = free, 1 = busy).
REQ-016 A page start SHALL be the first clock edge with rst_n high after reset, and every page toggle; at each page start, snap_free and snap_busy SHALL latch free and busy.
REQ-017 Input changes mid-page SHALL NOT affect the display until the next page start (no tearing).
REQ-018 Digit 0 SHALL show 'L' on page 0 and 'o' on page 1.
REQ-019 Digits 1..N_DIG-1 SHALL show the page's snapshot value in decimal, most significant digit first, on N_DIG-1 positions.
REQ-020 Leading zeros SHALL be blanked, except the rightmost digit; the value 0 SHALL show a single '0'.
REQ-021 If the snapshot value exceeds 10^(N_DIG-1)-1, all numeric digits SHALL show '-'.
REQ-022 Binary-to-decimal conversion SHALL be exact for all 2^CNT_W input values; it may be combinational or computed within the page start plus N_DIG cycles.
REQ-023 Glyph codes for seg SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, L=1000111, o=0100011, '-'=0111111, blank=1111111.
REQ-024 Outputs SHALL have 1-cycle latency: seg and dig SHALL reflect the new index in the cycle after the tick.
REQ-025 dig SHALL be all ones for exactly that first cycle of each slot (anti-ghosting); for the remaining SCAN_DIV-1 cycles, dig SHALL equal ~(1<<index).
REQ-026 The blink phase SHALL toggle every BLINK_FRAMES frame ends.
REQ-027 When snap_free==0 and the blink phase is 1, dig SHALL be all ones on both pages.
REQ-028 Page toggle, blink toggle and index wrap on the same tick SHALL all take effect together on that edge.

Reset
REQ-029 While rst_n=0, asynchronously: dig SHALL be all ones, seg SHALL be 1111111, dp SHALL be 1.
REQ-030 While rst_n=0: prescaler, index, frame counter, page, blink phase and snapshots SHALL all be 0.
REQ-031 Reset asserted mid-slot or mid-page SHALL abort the scan; after release, scanning SHALL restart at digit 0, page 0, with a fresh snapshot.

Verification
REQ-032 The bench SHALL cover this scenario (N_DIG=4, SCAN_DIV=4, PAGE_FRAMES=2, BLINK_FRAMES=1, CNT_W=4 unless noted): rst_n=0 -> dig=1111, seg=1111111, dp=1 with no clock running.
REQ-033 The bench SHALL cover: free=3, busy=1, release reset -> slots show L/blank/blank/3 (seg 1000111, 1111111, 1111111, 0110000), first slot cycle dig=1111, then 1110, 1101, 1011, 0111.
REQ-034 The bench SHALL cover: after 32 cycles -> page 1 shows o/blank/blank/1; changing free to 7 at cycle 10 -> page 0 still shows 3 until cycle 64.
REQ-035 The bench SHALL cover: free=0, busy=15 -> L/blank/blank/0 on even frames, dig=1111 for entire odd frames; page 1 shows o/blank/1/5 with same blink.
REQ-036 The bench SHALL cover: N_DIG=2, busy=15 -> page 1 shows o/'-' (0100011, 0111111); busy=9 -> o/9.
REQ-037 The bench SHALL cover: rst_n pulsed low at cycle 45 -> outputs blank immediately; after release, page 0, digit 0, new snapshot.
